enc_sample_sched: RTL and testbench
===================================

# enc_sample_sched

Periodic acquisition scheduler between the encoder core and the EMIF read path. It issues sample requests to the encoder core at a programmable period and enforces a req/ack handshake with timeout. It latches each returned 32-bit position into a snapshot register and serves it to the MCU as coherent 16-bit halves. A low-half read freezes the matching high half, so a snapshot update can never tear a 32-bit read across two EMIF cycles.

## Interface
Parameters:
- TIMEOUT_CYC, 1000: clk cycles `enc_req` may stay high without `enc_ack` before abort.
- LOCK_CYC, 256: clk cycles a low-half read lock persists before auto-release.

Ports:
- clk  in  1  200 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler enable, level.
- period_cfg  in  16  sample period in clk cycles; values 0 and 1 are treated as 2.
- enc_req  out  1  sample request to the encoder core.
- enc_ack  in  1  one-cycle acknowledge from the encoder core; `enc_data` is valid in the same cycle.
- enc_data  in  32  sampled encoder position.
- rd_en  in  1  one-cycle EMIF read strobe.
- rd_addr  in  2  read select: 0 = snap[15:0], 1 = snap[31:16], 2 = status, 3 = sample_cnt.
- rd_data  out  16  read data, registered.
- sample_valid  out  1  one-cycle pulse on each snapshot update.
- clr_err  in  1  clears the sticky error flags.
- timeout_err  out  1  sticky flag: handshake timeout occurred.

## Operation
- Reset: every output and register is 0. FSM enters IDLE; the lock is clear.
- Period counter:
  - Runs only while `enable` = 1.
  - Loads `max(period_cfg, 2) - 1` and counts down; at 0 it emits `tick` for one cycle and reloads.
  - `period_cfg` is sampled only at reload.
- FSM states and transitions:
  - IDLE: stays while `enable` = 0. On `enable` = 1, goes to WAIT and loads the counter.
  - WAIT: on `tick`, goes to REQ.
  - REQ: `enc_req` = 1.
    - On `enc_ack`: capture `enc_data` into shadow, go to LATCH.
    - When the timeout counter reaches TIMEOUT_CYC: set `timeout_err`, go to WAIT.
    - `enc_ack` and timeout in the same cycle: ack wins.
  - LATCH: if lock = 0, copy shadow to snap, increment `sample_cnt` (16-bit, wraps 0xFFFF→0), pulse `sample_valid`, go to WAIT. If lock = 1, stay.
- Overrun: a `tick` arriving while in REQ or LATCH sets sticky `overrun` and is otherwise discarded. The period counter keeps running.
- `enable` falling in any state:
  - Go to IDLE next cycle and drop `enc_req` that cycle.
  - Discard shadow; snap is unchanged.
  - Clear the counter.
- Read path:
  - `rd_en` with addr 0: return snap[15:0], copy snap[31:16] into hold_hi, set lock, load the lock timer.
  - addr 1: return hold_hi if lock = 1, otherwise snap[31:16]; clear lock.
  - addr 2: return {12'b0, busy, lock, overrun, timeout_err}, where busy = (state == REQ or LATCH).
  - addr 3: return sample_cnt.
  - Lock auto-clears when the lock timer expires after LOCK_CYC cycles.
  - A repeated addr 0 read while locked re-captures hold_hi and reloads the timer.
- `clr_err` clears `timeout_err` and `overrun`. If a new error occurs in the same cycle, set wins.

## Timing
- `enc_req` rises 1 cycle after `tick`. It falls in the cycle after `enc_ack`, or after the timeout.
- `enc_ack` → snap update and `sample_valid`: 2 cycles when unlocked. When locked: 1 cycle after the lock clears.
- `rd_en` → `rd_data` valid: 1 cycle; data is held until the next `rd_en`.
- Lock set by addr 0 takes effect the cycle after `rd_en`. A LATCH entered in that same cycle waits.
- With `period_cfg` = N ≥ 2, ticks are exactly N cycles apart.

## Structure
- Shared package `enc_sched_pkg`:
  - FSM state encoding (IDLE/WAIT/REQ/LATCH).
  - Read address constants.
  - Status bit positions.
  - Default TIMEOUT_CYC and LOCK_CYC.
- Sub-module `period_tick_gen`: down-counter with clamp and reload, emitting `tick`.
- Everything else (FSM, timeout counter, shadow/snap/hold_hi, lock timer, read mux) lives in the top block.

## Test plan
- Normal rate: `period_cfg` = 100, enable, `enc_ack` 5 cycles after each `enc_req` with data 0x1234_5678 → `sample_valid` every 100 cycles; addr 0/1 reads return 0x5678/0x1234; `sample_cnt` increments.
- Timeout: `enc_ack` never asserted → `enc_req` drops after 1000 cycles; `timeout_err` = 1; status reads 0x0001; `clr_err` → 0x0000.
- Coherency:
  - snap = 0xAAAA_BBBB; read addr 0 → 0xBBBB.
  - Ack new data 0xCCCC_DDDD → no `sample_valid`.
  - Read addr 1 → 0xAAAA; 1 cycle later snap = 0xCCCC_DDDD with a `sample_valid` pulse.
- Lock expiry: read addr 0, never read addr 1 → lock clears after 256 cycles; pending sample commits.
- Overrun and clamp:
  - `period_cfg` = 0 → ticks every 2 cycles.
  - `enc_ack` delayed 10 cycles → `overrun` = 1; only one `sample_valid` per handshake.
- Disable/reset mid-REQ:
  - Drop `enable` while `enc_req` = 1 → `enc_req` = 0 next cycle; snap unchanged.
  - Assert `rst_n` = 0 mid-transfer → all outputs 0 immediately.

Source files
------------

// File: rtl/enc_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_sched_pkg : shared encodings for the encoder sample scheduler
// rev 1.0
// ------------------------------------------------------------------
package enc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REQ   = 2'd2,
    ST_LATCH = 2'd3
  } sched_state_e;

  localparam logic [1:0] RD_SNAP_LO = 2'd0;
  localparam logic [1:0] RD_SNAP_HI = 2'd1;
  localparam logic [1:0] RD_STATUS  = 2'd2;
  localparam logic [1:0] RD_CNT     = 2'd3;

  localparam int STAT_TERR_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;
  localparam int STAT_LOCK_BIT = 2;
  localparam int STAT_BUSY_BIT = 3;

  localparam int TIMEOUT_CYC_DEFAULT = 1000;
  localparam int LOCK_CYC_DEFAULT    = 256;

  // Periods below 2 cannot produce a distinct reload/tick cycle.
  function automatic logic [15:0] clamp_period(input logic [15:0] cfg);
    return (cfg < 16'd2) ? 16'd2 : cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/period_tick_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// period_tick_gen : clamped down-counter emitting a one-cycle tick
// rev 1.0
// ------------------------------------------------------------------
module period_tick_gen
  import enc_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] period_cfg_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload;

  assign reload = clamp_period(period_cfg_i) - 16'd1;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = reload;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = reload;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/enc_sample_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_sample_sched : periodic encoder sampling with tear-free readout
// rev 1.0
// ------------------------------------------------------------------
module enc_sample_sched
  import enc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int LOCK_CYC    = LOCK_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] period_cfg,
  output logic        enc_req,
  input  logic        enc_ack,
  input  logic [31:0] enc_data,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        sample_valid,
  input  logic        clr_err,
  output logic        timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int LK_W = $clog2(LOCK_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYC - 1);

  sched_state_e    state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     snap_q, snap_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     hold_q, hold_d;
  logic            lock_q, lock_d;
  logic [LK_W-1:0] ltmr_q, ltmr_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            sv_q, sv_d;
  logic            ovr_q, ovr_d;
  logic            terr_q, terr_d;
  logic            tick, load, busy, ovr_set, terr_set;
  logic [15:0]     status;

  period_tick_gen u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (enable),
    .load_i       (load),
    .period_cfg_i (period_cfg),
    .tick_o       (tick)
  );

  assign busy = (state_q == ST_REQ) || (state_q == ST_LATCH);

  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    sv_d     = 1'b0;
    load     = 1'b0;
    ovr_set  = 1'b0;
    terr_set = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      to_d     = '0;
      shadow_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          load    = 1'b1;
        end
        ST_WAIT: begin
          if (tick) begin
            state_d = ST_REQ;
            to_d    = '0;
          end
        end
        ST_REQ: begin
          ovr_set = tick;
          // An ack landing on the last allowed cycle still counts.
          if (enc_ack) begin
            shadow_d = enc_data;
            state_d  = ST_LATCH;
          end else if (to_q == TO_LAST) begin
            terr_set = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_LATCH: begin
          ovr_set = tick;
          if (!lock_q) begin
            snap_d  = shadow_q;
            cnt_d   = cnt_q + 16'd1;
            sv_d    = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    terr_d = terr_set | (terr_q & ~clr_err);
    ovr_d  = ovr_set  | (ovr_q  & ~clr_err);
  end

  always_comb begin
    status                = '0;
    status[STAT_TERR_BIT] = terr_q;
    status[STAT_OVR_BIT]  = ovr_q;
    status[STAT_LOCK_BIT] = lock_q;
    status[STAT_BUSY_BIT] = busy;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    ltmr_d    = ltmr_q;
    if (lock_q) begin
      if (ltmr_q == '0) lock_d = 1'b0;
      else              ltmr_d = ltmr_q - LK_W'(1);
    end
    if (rd_en) begin
      case (rd_addr)
        RD_SNAP_LO: begin
          rd_data_d = snap_q[15:0];
          hold_d    = snap_q[31:16];
          lock_d    = 1'b1;
          ltmr_d    = LK_LAST;
        end
        RD_SNAP_HI: begin
          rd_data_d = lock_q ? hold_q : snap_q[31:16];
          lock_d    = 1'b0;
        end
        RD_STATUS: rd_data_d = status;
        default:   rd_data_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      to_q      <= '0;
      shadow_q  <= '0;
      snap_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      lock_q    <= 1'b0;
      ltmr_q    <= '0;
      rd_data_q <= '0;
      sv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      shadow_q  <= shadow_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      ltmr_q    <= ltmr_d;
      rd_data_q <= rd_data_d;
      sv_q      <= sv_d;
      ovr_q     <= ovr_d;
      terr_q    <= terr_d;
    end
  end

  assign enc_req      = (state_q == ST_REQ);
  assign rd_data      = rd_data_q;
  assign sample_valid = sv_q;
  assign timeout_err  = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_sample_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_enc_sample_sched : randomized bench with timestamp-based model
// rev 1.0
// ------------------------------------------------------------------
module tb_enc_sample_sched;

  localparam int TO = 1000;
  localparam int LK = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period_cfg = '0;
  logic        enc_req;
  logic        enc_ack = 1'b0;
  logic [31:0] enc_data = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        sample_valid;
  logic        clr_err = 1'b0;
  logic        timeout_err;

  enc_sample_sched #(.TIMEOUT_CYC(TO), .LOCK_CYC(LK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period_cfg   (period_cfg),
    .enc_req      (enc_req),
    .enc_ack      (enc_ack),
    .enc_data     (enc_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .sample_valid (sample_valid),
    .clr_err      (clr_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: scheduler described by absolute cycle timestamps.
  int          cyc = 0;
  bit          m_active, m_req, m_pend, m_sv, m_ovr, m_terr;
  int          next_tick, req_start, lock_end;
  logic [31:0] m_pend_data, m_snap;
  logic [15:0] m_hold, m_cnt, m_rd;

  function automatic int eff_period(input logic [15:0] c);
    return (c < 16'd2) ? 2 : int'(c);
  endfunction

  task automatic model_reset();
    m_active = 0; m_req = 0; m_pend = 0; m_sv = 0; m_ovr = 0; m_terr = 0;
    next_tick = 0; req_start = 0; lock_end = -1;
    m_pend_data = '0; m_snap = '0; m_hold = '0; m_cnt = '0; m_rd = '0;
  endtask

  task automatic model_step();
    int          p        = cyc;
    bit          locked   = (p <= lock_end);
    bit          tick     = enable && m_active && (p == next_tick);
    bit          busy_pre = m_req || m_pend;
    logic [31:0] snap_pre = m_snap;
    bit          terr_set = 0;
    bit          ovr_set  = 0;
    m_sv = 0;
    if (rd_en) begin
      case (rd_addr)
        2'd0: begin m_rd = snap_pre[15:0]; m_hold = snap_pre[31:16]; lock_end = p + LK; end
        2'd1: begin m_rd = locked ? m_hold : snap_pre[31:16]; lock_end = -1; end
        2'd2: m_rd = {12'b0, busy_pre, locked, m_ovr, m_terr};
        default: m_rd = m_cnt;
      endcase
    end
    if (!enable) begin
      m_active = 0; m_req = 0; m_pend = 0;
    end else if (!m_active) begin
      m_active  = 1;
      next_tick = p + eff_period(period_cfg);
    end else begin
      if (tick) next_tick = p + eff_period(period_cfg);
      if (m_req) begin
        if (tick) ovr_set = 1;
        if (enc_ack) begin
          m_req = 0; m_pend = 1; m_pend_data = enc_data;
        end else if (p - req_start + 1 >= TO) begin
          m_req = 0; terr_set = 1;
        end
      end else if (m_pend) begin
        if (tick) ovr_set = 1;
        if (!locked) begin
          m_snap = m_pend_data; m_cnt = m_cnt + 16'd1; m_sv = 1; m_pend = 0;
        end
      end else if (tick) begin
        m_req = 1; req_start = p + 1;
      end
    end
    if (terr_set) m_terr = 1; else if (clr_err) m_terr = 0;
    if (ovr_set)  m_ovr  = 1; else if (clr_err) m_ovr  = 0;
  endtask

  // Encoder responder and per-cycle checking.
  bit          ack_on    = 1;
  int          ack_delay = 5;
  int          req_age   = 0;
  int          sv_cnt    = 0;
  logic [31:0] next_data = '0;

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    cyc++;
    #1;
    check("enc_req", enc_req, m_req);
    check("sample_valid", sample_valid, m_sv);
    check("timeout_err", timeout_err, m_terr);
    check("rd_data", rd_data, m_rd);
    if (sample_valid) sv_cnt++;
    req_age = enc_req ? req_age + 1 : 0;
    enc_ack = ack_on && enc_req && (req_age == ack_delay);
    if (enc_ack) enc_data = next_data;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!enc_req && n < budget) begin step(); n++; end
    check("wait_req", enc_req, 1'b1);
  endtask

  task automatic wait_sv(input int budget);
    int n = 0;
    while (!sample_valid && n < budget) begin step(); n++; end
    check("wait_sample_valid", sample_valid, 1'b1);
  endtask

  task automatic restart(input logic [15:0] cfg);
    enable = 1'b0;
    step();
    period_cfg = cfg;
    enable     = 1'b1;
  endtask

  initial begin
    int          n;
    logic [31:0] snap_keep;
    model_reset();

    steps(2);
    check("rst_enc_req", enc_req, 1'b0);
    check("rst_rd_data", rd_data, 16'h0);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Normal rate
    ack_on = 1; ack_delay = 5; next_data = 32'h1234_5678;
    restart(16'd100);
    wait_sv(300);
    n = 0;
    do begin step(); n++; end while (!sample_valid && n < 300);
    check("norm_sv_spacing", n, 100);
    steps(20);
    rd(2'd0); check("norm_lo", rd_data, 16'h5678);
    rd(2'd1); check("norm_hi", rd_data, 16'h1234);
    rd(2'd3); check("norm_cnt", rd_data, 16'd2);

    // Timeout
    ack_on = 0;
    restart(16'd2000);
    wait_req(2100);
    n = 0;
    while (enc_req && n < TO + 100) begin n++; step(); end
    check("timeout_len", n, TO);
    check("timeout_flag", timeout_err, 1'b1);
    rd(2'd2); check("timeout_status", rd_data, 16'h0001);
    clr_err = 1'b1; step();
    rd(2'd2); check("cleared_status", rd_data, 16'h0000);

    // Coherency
    ack_on = 1; ack_delay = 3; next_data = 32'hAAAA_BBBB;
    restart(16'd60);
    wait_sv(200);
    rd(2'd0); check("coh_lo", rd_data, 16'hBBBB);
    next_data = 32'hCCCC_DDDD;
    n = sv_cnt;
    wait_req(100);
    steps(10);
    check("coh_no_sv_while_locked", sv_cnt - n, 0);
    rd(2'd1); check("coh_hi", rd_data, 16'hAAAA);
    step();   check("coh_sv_after_unlock", sample_valid, 1'b1);
    rd(2'd0); check("coh_new_lo", rd_data, 16'hDDDD);
    rd(2'd1); check("coh_new_hi", rd_data, 16'hCCCC);

    // Lock expiry
    next_data = 32'h0BAD_F00D;
    rd(2'd0);
    n = 1;
    while (!sample_valid && n < LK + 40) begin step(); n++; end
    check("lock_expiry_latency", n, LK + 2);
    rd(2'd0); check("lock_commit_lo", rd_data, 16'hF00D);
    rd(2'd1); check("lock_commit_hi", rd_data, 16'h0BAD);

    // Overrun with clamped period
    clr_err = 1'b1; step();
    ack_delay = 10; next_data = 32'h5555_0001;
    restart(16'd0);
    wait_sv(100);
    n = sv_cnt;
    steps(60);
    rd(2'd2); check("overrun_bit", rd_data[1], 1'b1);
    check("overrun_some_samples", (sv_cnt - n) > 0, 1'b1);

    // Disable mid-REQ
    ack_on = 0;
    restart(16'd20);
    wait_req(100);
    snap_keep = m_snap;
    steps(2);
    enable = 1'b0;
    step();   check("disable_drops_req", enc_req, 1'b0);
    rd(2'd0); check("disable_snap_lo", rd_data, snap_keep[15:0]);
    rd(2'd1); check("disable_snap_hi", rd_data, snap_keep[31:16]);

    // Randomized traffic
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) begin
        period_cfg = 16'($urandom_range(0, 40));
        ack_delay  = $urandom_range(1, 15);
        ack_on     = ($urandom_range(0, 7) != 0);
      end
      next_data = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rd_en   = 1'b1;
        rd_addr = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) clr_err = 1'b1;
      step();
    end

    // Reset mid-transfer
    enable = 1'b1; ack_on = 1; ack_delay = 8; period_cfg = 16'd30;
    rd(2'd3);
    wait_req(100);
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_enc_req", enc_req, 1'b0);
    check("arst_rd_data", rd_data, 16'h0);
    check("arst_sample_valid", sample_valid, 1'b0);
    check("arst_timeout_err", timeout_err, 1'b0);
    steps(2);
    rst_n = 1'b1;
    steps(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
